// File: rtl/avalon_pkg.sv
// avalon_pkg: region map, response codes and FSM states for the Avalon-MM front end
package avalon_pkg;
  localparam logic [12:0] PIX_BASE = 13'd0;
  localparam logic [12:0] WGT_BASE = 13'd1024;
  localparam logic [12:0] OUT_BASE = 13'd4115;
  localparam logic [12:0] CONTROL_REG = 13'd4126;
  localparam logic [12:0] STATUS_REG = 13'd4127;
  typedef enum logic [1:0] {OKAY = 2'b00, DECERR = 2'b11} resp_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK, RDATA} state_t;
  typedef enum logic [2:0] {R_PIX, R_WGT, R_OUT, R_CTRL, R_STAT, R_NONE} region_t;
endpackage

// File: rtl/avalon_addr_decode.sv
// avalon_addr_decode: maps a word address to its region and region-relative offset
module avalon_addr_decode
  import avalon_pkg::*;
(
  input  logic [12:0] addr,
  output region_t     region,
  output logic [11:0] offset
);
  logic [12:0] base;
  always_comb begin
    region = addr < WGT_BASE ? R_PIX : addr < OUT_BASE ? R_WGT : addr < CONTROL_REG ? R_OUT :
             addr == CONTROL_REG ? R_CTRL : addr == STATUS_REG ? R_STAT : R_NONE;
    base = region == R_WGT ? WGT_BASE : region == R_OUT ? OUT_BASE : PIX_BASE;
  end
  assign offset = 12'(addr - base);
endmodule

// File: rtl/avalon_interface.sv
// avalon_interface: Avalon-MM slave decoding host traffic into RAM ports and control/status registers
module avalon_interface
  import avalon_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        write,
  input  logic        read,
  input  logic        beginbursttransfer,
  input  logic [9:0]  burstcount,
  input  logic [12:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        writeresponsevalid,
  output logic [1:0]  response,
  output logic        waitrequest,
  input  logic [16:0] result_output,
  input  logic        done_calc,
  input  logic        overflow,
  output logic [11:0] weight_address,
  output logic [9:0]  pixel_address,
  output logic        w_enable_weights,
  output logic        w_enable_pixels,
  output logic [15:0] store_data,
  output logic [3:0]  output_address,
  output logic        start_calc,
  output logic        clear_data
);
  state_t state, next;
  region_t region, region_q;
  resp_t resp_q;
  logic [11:0] offset;
  logic [12:0] addr_q, cap_addr;
  logic [31:0] data_q, ctrl_q;
  logic [9:0] rem_q;
  logic wr_q, burst_q, err_q, bad, go, ack_wr;
  assign cap_addr = burst_q ? addr_q + 13'd1 : address;
  assign bad = region == R_NONE || (burst_q && err_q);
  assign go = !(burst_q && !write);
  assign ack_wr = state == ACK && wr_q;
  avalon_addr_decode u_dec (.addr(cap_addr), .region(region), .offset(offset));
  always_comb begin
    next = state == IDLE ? ((read || write) ? CAPTURE : IDLE) :
           state == CAPTURE ? (go ? ACK : IDLE) :
           state == ACK ? (!wr_q ? RDATA : (burst_q && rem_q > 10'd1) ? CAPTURE : IDLE) : IDLE;
    waitrequest = state != ACK;
    readdatavalid = state == RDATA;
    writeresponsevalid = ack_wr;
    w_enable_pixels = ack_wr && region_q == R_PIX;
    w_enable_weights = ack_wr && region_q == R_WGT;
    response = resp_q;
    readdata = state != RDATA ? 32'd0 :
               region_q == R_OUT ? {{15{result_output[16]}}, result_output} :
               region_q == R_CTRL ? ctrl_q :
               region_q == R_STAT ? {30'd0, overflow, done_calc} : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
      region_q <= R_NONE;
      resp_q <= OKAY;
      addr_q <= '0;
      data_q <= '0;
      ctrl_q <= '0;
      rem_q <= '0;
      wr_q <= 1'b0;
      burst_q <= 1'b0;
      err_q <= 1'b0;
      pixel_address <= '0;
      weight_address <= '0;
      output_address <= '0;
      store_data <= '0;
      start_calc <= 1'b0;
      clear_data <= 1'b0;
    end else begin
      state <= next;
      start_calc <= ack_wr && region_q == R_CTRL && data_q[0];
      clear_data <= ack_wr && region_q == R_CTRL && data_q[1];
      if (state == CAPTURE && go) begin
        addr_q <= cap_addr;
        data_q <= writedata;
        wr_q <= write;
        err_q <= bad;
        resp_q <= bad ? DECERR : OKAY;
        region_q <= bad ? R_NONE : region;
        if (!burst_q && write && beginbursttransfer) begin
          burst_q <= 1'b1;
          rem_q <= burstcount == 10'd0 ? 10'd1 : burstcount;
        end
        if (!bad && write) store_data <= writedata[15:0];
        if (!bad && region == R_PIX) pixel_address <= offset[9:0];
        if (!bad && region == R_WGT) weight_address <= offset;
        if (!bad && region == R_OUT) output_address <= offset[3:0];
      end
      if (state == CAPTURE && !go) burst_q <= 1'b0;
      if (state == ACK) begin
        if (ack_wr && region_q == R_CTRL) ctrl_q <= data_q;
        if (burst_q) rem_q <= rem_q - 10'd1;
        if (!(burst_q && rem_q > 10'd1)) burst_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_avalon_interface.sv
// tb_avalon_interface: directed self-checking bench for avalon_interface
module tb_avalon_interface;
  logic clk = 1'b0, n_rst = 1'b1;
  logic write = 1'b0, read = 1'b0, beginbursttransfer = 1'b0;
  logic [9:0] burstcount = '0;
  logic [12:0] address = '0;
  logic [31:0] writedata = '0, readdata;
  logic readdatavalid, writeresponsevalid, waitrequest;
  logic [1:0] response;
  logic [16:0] result_output = '0;
  logic done_calc = 1'b0, overflow = 1'b0;
  logic [11:0] weight_address;
  logic [9:0] pixel_address;
  logic w_enable_weights, w_enable_pixels;
  logic [15:0] store_data;
  logic [3:0] output_address;
  logic start_calc, clear_data;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  avalon_interface dut (
    .clk(clk), .n_rst(n_rst), .write(write), .read(read),
    .beginbursttransfer(beginbursttransfer), .burstcount(burstcount),
    .address(address), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .writeresponsevalid(writeresponsevalid),
    .response(response), .waitrequest(waitrequest), .result_output(result_output),
    .done_calc(done_calc), .overflow(overflow), .weight_address(weight_address),
    .pixel_address(pixel_address), .w_enable_weights(w_enable_weights),
    .w_enable_pixels(w_enable_pixels), .store_data(store_data),
    .output_address(output_address), .start_calc(start_calc), .clear_data(clear_data)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (waitrequest && n < 20);
    check(tag, 32'(waitrequest), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    check("rst_wait", 32'(waitrequest), 32'd1);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_resp", 32'(response), 32'd0);
    check("rst_oaddr", 32'(output_address), 32'd0);
    check("rst_start", 32'(start_calc), 32'd0);
    n_rst = 1'b0;
    tick();
    address = 13'd4126;
    writedata = 32'h0000000F;
    write = 1'b1;
    wait_ack("ctrl_wr_ack");
    check("ctrl_wr_resp", 32'(response), 32'd0);
    check("ctrl_wr_wrv", 32'(writeresponsevalid), 32'd1);
    check("ctrl_wr_start_early", 32'(start_calc), 32'd0);
    write = 1'b0;
    tick();
    check("ctrl_start", 32'(start_calc), 32'd1);
    check("ctrl_clear", 32'(clear_data), 32'd1);
    tick();
    check("ctrl_start_end", 32'(start_calc), 32'd0);
    check("ctrl_clear_end", 32'(clear_data), 32'd0);
    read = 1'b1;
    wait_ack("ctrl_rd_ack");
    check("ctrl_rd_rdv_early", 32'(readdatavalid), 32'd0);
    read = 1'b0;
    tick();
    check("ctrl_rd_rdv", 32'(readdatavalid), 32'd1);
    check("ctrl_rd_data", readdata, 32'h0000000F);
    check("ctrl_rd_nostart", 32'(start_calc), 32'd0);
    address = 13'd1030;
    writedata = 32'h00012345;
    write = 1'b1;
    wait_ack("wgt_ack");
    check("wgt_addr", 32'(weight_address), 32'd6);
    check("wgt_data", 32'(store_data), 32'h2345);
    check("wgt_wen", 32'(w_enable_weights), 32'd1);
    check("wgt_pen", 32'(w_enable_pixels), 32'd0);
    write = 1'b0;
    tick();
    check("wgt_wen_end", 32'(w_enable_weights), 32'd0);
    address = 13'd0;
    burstcount = 10'd196;
    beginbursttransfer = 1'b1;
    writedata = 32'd0;
    write = 1'b1;
    for (int i = 0; i < 196; i++) begin
      wait_ack("burst_ack");
      check("burst_paddr", 32'(pixel_address), 32'(i));
      check("burst_data", 32'(store_data), 32'(2 * i));
      check("burst_wen", 32'(w_enable_pixels), 32'd1);
      check("burst_resp", 32'(response), 32'd0);
      beginbursttransfer = 1'b0;
      address = 13'h1FFF;
      writedata = 32'(2 * (i + 1));
      if (i == 195) write = 1'b0;
    end
    tick();
    check("burst_end_wait", 32'(waitrequest), 32'd1);
    check("burst_end_wen", 32'(w_enable_pixels), 32'd0);
    address = 13'd4127;
    burstcount = 10'd3;
    beginbursttransfer = 1'b1;
    write = 1'b1;
    wait_ack("ub_ack0");
    check("ub_resp0", 32'(response), 32'd0);
    beginbursttransfer = 1'b0;
    wait_ack("ub_ack1");
    check("ub_resp1", 32'(response), 32'd3);
    check("ub_pen1", 32'(w_enable_pixels), 32'd0);
    wait_ack("ub_ack2");
    check("ub_resp2", 32'(response), 32'd3);
    check("ub_wrv2", 32'(writeresponsevalid), 32'd1);
    check("ub_wen2", 32'(w_enable_weights), 32'd0);
    write = 1'b0;
    tick();
    tick();
    check("ub_no_extra", 32'(waitrequest), 32'd1);
    address = 13'd5000;
    read = 1'b1;
    wait_ack("unm_ack");
    check("unm_resp", 32'(response), 32'd3);
    check("unm_pen", 32'(w_enable_pixels), 32'd0);
    check("unm_wen", 32'(w_enable_weights), 32'd0);
    read = 1'b0;
    tick();
    check("unm_rdv", 32'(readdatavalid), 32'd1);
    check("unm_data", readdata, 32'd0);
    result_output = 17'h1ABCD;
    address = 13'd4125;
    read = 1'b1;
    wait_ack("res10_ack");
    check("res10_oaddr", 32'(output_address), 32'd10);
    check("res10_resp", 32'(response), 32'd0);
    read = 1'b0;
    tick();
    check("res10_data", readdata, 32'hFFFFABCD);
    tick();
    check("res10_hold", 32'(output_address), 32'd10);
    result_output = 17'h00123;
    address = 13'd4124;
    read = 1'b1;
    wait_ack("res9_ack");
    check("res9_oaddr", 32'(output_address), 32'd9);
    read = 1'b0;
    tick();
    check("res9_data", readdata, 32'h00000123);
    done_calc = 1'b1;
    overflow = 1'b0;
    address = 13'd4127;
    read = 1'b1;
    wait_ack("stat_ack");
    read = 1'b0;
    tick();
    check("stat_done", readdata, 32'h00000001);
    done_calc = 1'b0;
    overflow = 1'b1;
    read = 1'b1;
    wait_ack("stat2_ack");
    read = 1'b0;
    tick();
    check("stat_ovf", readdata, 32'h00000002);
    address = 13'd5;
    writedata = 32'd7;
    write = 1'b1;
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    check("mid_rst_wait", 32'(waitrequest), 32'd1);
    check("mid_rst_pen", 32'(w_enable_pixels), 32'd0);
    check("mid_rst_paddr", 32'(pixel_address), 32'd0);
    n_rst = 1'b0;
    write = 1'b0;
    tick();
    check("mid_rst_pen2", 32'(w_enable_pixels), 32'd0);
    check("mid_rst_wait2", 32'(waitrequest), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
